// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and counter sizing for the muldiv unit.
// The DIV state exists only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIN
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_FIN
  } state_e;
`endif

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// compare against the divisor, subtract when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {1'b0, div_i});
    // Remainder after subtraction is always below the divisor, so it fits WIDTH bits.
    rem_o   = q_o ? WIDTH'(shifted - {1'b0, div_i}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIVU only pulses done.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // acc holds the product in MUL, and {remainder, dividend/quotient} in DIV.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [2*WIDTH-1:0]   mul_sum;

  assign mul_sum = acc_q + (mplr_q[0] ? mcand_q : '0);

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0]   rem_nxt;
  logic               qbit;
  logic [2*WIDTH-1:0] div_acc;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i (acc_q[WIDTH-1]),
    .div_i (mplr_q),
    .rem_o (rem_nxt),
    .q_o   (qbit)
  );

  assign div_acc = {rem_nxt, acc_q[WIDTH-2:0], qbit};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        if (start) begin
          cnt_d = '0;
          case (op)
            OP_MULTU: begin
              state_d = ST_MUL;
              acc_d   = '0;
              mcand_d = {{WIDTH{1'b0}}, a};
              mplr_d  = b;
            end
            OP_DIVU: begin
`ifdef MULDIV_DIV_EN
              state_d = ST_DIV;
              acc_d   = {{WIDTH{1'b0}}, a};
              mplr_d  = b;
`else
              state_d = ST_FIN;
`endif
            end
            OP_MTHI: begin
              state_d = ST_FIN;
              hi_d    = a;
            end
            default: begin
              state_d = ST_FIN;
              lo_d    = a;
            end
          endcase
        end
      end
      ST_MUL: begin
        acc_d   = mul_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d      = ST_FIN;
          {hi_d, lo_d} = mul_sum;
        end
      end
`ifdef MULDIV_DIV_EN
      ST_DIV: begin
        acc_d = div_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d      = ST_FIN;
          {hi_d, lo_d} = div_acc;
          dbz_d        = (mplr_q == '0);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef MULDIV_DIV_EN
    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV);
`else
    busy_d = (state_d == ST_MUL);
`endif
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
